// File: rtl/conv_pool_pkg.sv
// rtl/conv_pool_pkg.sv - shared widths, types and field accessors for the conv/pool engine
package conv_pool_pkg;

    localparam int PIX_W      = 8;
    localparam int COEF_W     = 8;
    localparam int ACC_W      = 22;
    localparam int NUM_BLOCKS = 65025;
    localparam int ADDR_W     = 16;

    localparam int BLK_W      = 16 * PIX_W;
    localparam int KER_W      = 9 * COEF_W;
    localparam int NUM_CH     = 3;
    localparam int NUM_TAPS   = NUM_CH * 9;

    typedef logic        [PIX_W-1:0]  pixel_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

    // Pixel p[r][c] of a packed 4x4 block.
    function automatic pixel_t get_pixel(input logic [BLK_W-1:0] blk, input int r, input int c);
        return blk[PIX_W*(4*r+c) +: PIX_W];
    endfunction

    // Coefficient k[i][j] of a packed 3x3 kernel.
    function automatic coef_t get_coef(input logic [KER_W-1:0] ker, input int i, input int j);
        return coef_t'(ker[COEF_W*(3*i+j) +: COEF_W]);
    endfunction

    // Unsigned pixel times signed coefficient, widened to the accumulator width.
    function automatic acc_t mul_px(input pixel_t p, input coef_t c);
        return acc_t'($signed({1'b0, p})) * acc_t'(c);
    endfunction

endpackage

// File: rtl/conv_pool_win.sv
// rtl/conv_pool_win.sv - one 3x3x3 convolution window, products then sum, two register stages
module conv_pool_win
    import conv_pool_pkg::*;
#(
    parameter int ROW_OFF = 0,
    parameter int COL_OFF = 0
) (
    input  logic             clk_i,
    input  logic [BLK_W-1:0] img_r_i,
    input  logic [BLK_W-1:0] img_g_i,
    input  logic [BLK_W-1:0] img_b_i,
    input  logic [KER_W-1:0] ker_r_i,
    input  logic [KER_W-1:0] ker_g_i,
    input  logic [KER_W-1:0] ker_b_i,
    output acc_t             sum_o
);

    logic [BLK_W-1:0] img [NUM_CH];
    logic [KER_W-1:0] ker [NUM_CH];

    assign img[0] = img_r_i;
    assign img[1] = img_g_i;
    assign img[2] = img_b_i;
    assign ker[0] = ker_r_i;
    assign ker[1] = ker_g_i;
    assign ker[2] = ker_b_i;

    acc_t prod_d [NUM_TAPS];
    acc_t prod_q [NUM_TAPS];
    acc_t sum_d;
    acc_t sum_q;

    // All 27 pixel-by-coefficient products of this window position.
    always_comb begin
        prod_d = '{default: '0};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    prod_d[9*ch + 3*i + j] = mul_px(get_pixel(img[ch], ROW_OFF + i, COL_OFF + j),
                                                    get_coef(ker[ch], i, j));
                end
            end
        end
    end

    // Product register; validity is tracked by the top-level delay line.
    always_ff @(posedge clk_i) begin
        prod_q <= prod_d;
    end

    // Sum across all channels and taps; 22 bits cannot overflow for 27 products.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            sum_d = sum_d + prod_q[k];
        end
    end

    // Sum register.
    always_ff @(posedge clk_i) begin
        sum_q <= sum_d;
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/conv_pool.sv
// rtl/conv_pool.sv - streaming conv + max-pool engine: read issue, valid/address pipeline, pool, clamp
module conv_pool
    import conv_pool_pkg::*;
#(
    parameter int NUM_BLOCKS = conv_pool_pkg::NUM_BLOCKS,
    parameter int ADDR_W     = conv_pool_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BLK_W-1:0]  image_4x4_r,
    input  logic [BLK_W-1:0]  image_4x4_g,
    input  logic [BLK_W-1:0]  image_4x4_b,
    input  logic [KER_W-1:0]  kernel_r,
    input  logic [KER_W-1:0]  kernel_g,
    input  logic [KER_W-1:0]  kernel_b,
    output logic              input_re,
    output logic [ADDR_W-1:0] input_addr,
    output logic              output_we,
    output logic [ADDR_W-1:0] output_addr,
    output logic [7:0]        y
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLOCKS - 1);

    state_t            state_q, state_d;
    logic              re_q, re_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Read-issue state and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_START;
            re_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            re_q    <= re_d;
            addr_q  <= addr_d;
        end
    end

    // One read per cycle from address 0 to the last block, then idle until reset.
    always_comb begin
        state_d = state_q;
        re_d    = 1'b0;
        addr_d  = '0;
        case (state_q)
            ST_START: begin
                state_d = ST_RUN;
                re_d    = 1'b1;
                addr_d  = '0;
            end
            ST_RUN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    re_d   = 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    assign input_re   = re_q;
    assign input_addr = addr_q;

    // Four window positions of the 2x2 convolution output.
    acc_t conv [4];

    for (genvar a = 0; a < 2; a++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_col
            conv_pool_win #(
                .ROW_OFF (a),
                .COL_OFF (b)
            ) u_win (
                .clk_i   (clk),
                .img_r_i (image_4x4_r),
                .img_g_i (image_4x4_g),
                .img_b_i (image_4x4_b),
                .ker_r_i (kernel_r),
                .ker_g_i (kernel_g),
                .ker_b_i (kernel_b),
                .sum_o   (conv[2*a + b])
            );
        end
    end

    // vld0: data on the image bus; vld1: products held; vld2: sums held; we: result held.
    logic              vld0_q, vld1_q, vld2_q, we_q;
    logic [ADDR_W-1:0] a0_q, a1_q, a2_q, oaddr_q;
    logic [7:0]        y_q, y_d;
    acc_t              max01, max23, max_all;

    // Signed max of the four sums, then clamp to an unsigned byte.
    always_comb begin
        max01   = (conv[0] > conv[1]) ? conv[0] : conv[1];
        max23   = (conv[2] > conv[3]) ? conv[2] : conv[3];
        max_all = (max01 > max23) ? max01 : max23;
        if (max_all < 0) begin
            y_d = 8'd0;
        end else if (max_all > acc_t'(255)) begin
            y_d = 8'd255;
        end else begin
            y_d = max_all[7:0];
        end
    end

    // Valid/address delay line aligned with the window pipeline; reset drops in-flight blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            we_q    <= 1'b0;
            a0_q    <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            oaddr_q <= '0;
            y_q     <= '0;
        end else begin
            vld0_q <= re_q;
            vld1_q <= vld0_q;
            vld2_q <= vld1_q;
            we_q   <= vld2_q;
            a0_q   <= addr_q;
            a1_q   <= a0_q;
            a2_q   <= a1_q;
            if (vld2_q) begin
                oaddr_q <= a2_q;
                y_q     <= y_d;
            end
        end
    end

    assign output_we   = we_q;
    assign output_addr = oaddr_q;
    assign y           = y_q;

endmodule

// File: tb/tb_conv_pool.sv
// tb/tb_conv_pool.sv - randomized and directed checks of conv_pool against a behavioural model
module tb_conv_pool;

    localparam int N    = 200;
    localparam int AW   = 16;
    localparam int MAXC = N + 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [127:0]  img_r, img_g, img_b;
    logic [71:0]   kern [3];
    logic          input_re, output_we;
    logic [AW-1:0] input_addr, output_addr;
    logic [7:0]    y;

    int tests = 0;
    int fails = 0;

    logic [127:0]  mem [3][N];

    logic          cap_re    [MAXC];
    logic          cap_we    [MAXC];
    logic [AW-1:0] cap_addr  [MAXC];
    logic [AW-1:0] cap_oaddr [MAXC];
    logic [7:0]    cap_y     [MAXC];

    always #5 clk = ~clk;

    conv_pool #(
        .NUM_BLOCKS (N),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .image_4x4_r (img_r),
        .image_4x4_g (img_g),
        .image_4x4_b (img_b),
        .kernel_r    (kern[0]),
        .kernel_g    (kern[1]),
        .kernel_b    (kern[2]),
        .input_re    (input_re),
        .input_addr  (input_addr),
        .output_we   (output_we),
        .output_addr (output_addr),
        .y           (y)
    );

    // Image memory: one-cycle read latency, zeros when not enabled.
    always @(posedge clk) begin
        if (input_re === 1'b1 && int'(input_addr) < N) begin
            img_r <= mem[0][int'(input_addr)];
            img_g <= mem[1][int'(input_addr)];
            img_b <= mem[2][int'(input_addr)];
        end else begin
            img_r <= '0;
            img_g <= '0;
            img_b <= '0;
        end
    end

    // Expected result byte for block n, straight from the arithmetic definition.
    function automatic int ref_y(int n);
        int best;
        int s;
        int px;
        logic signed [7:0] cf;
        best = 0;
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                s = 0;
                for (int ch = 0; ch < 3; ch++) begin
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            px = int'(mem[ch][n][8*(4*(a+i) + (b+j)) +: 8]);
                            cf = kern[ch][8*(3*i+j) +: 8];
                            s  = s + px * int'(cf);
                        end
                    end
                end
                if ((a == 0 && b == 0) || s > best) best = s;
            end
        end
        if (best < 0) return 0;
        if (best > 255) return 255;
        return best;
    endfunction

    task automatic fill_mem_random();
        for (int ch = 0; ch < 3; ch++)
            for (int n = 0; n < N; n++)
                for (int p = 0; p < 16; p++)
                    mem[ch][n][8*p +: 8] = 8'($urandom);
    endtask

    task automatic fill_mem_const(logic [127:0] r, logic [127:0] g, logic [127:0] b);
        for (int n = 0; n < N; n++) begin
            mem[0][n] = r;
            mem[1][n] = g;
            mem[2][n] = b;
        end
    endtask

    task automatic fill_kern_random();
        for (int ch = 0; ch < 3; ch++)
            for (int t = 0; t < 9; t++)
                kern[ch][8*t +: 8] = 8'($urandom);
    endtask

    // Ends on the falling edge of the first cycle in which reads are issued.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic capture(int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            cap_re[k]    = input_re;
            cap_addr[k]  = input_addr;
            cap_we[k]    = output_we;
            cap_oaddr[k] = output_addr;
            cap_y[k]     = y;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (input_re !== 1'b0)     begin fails++; $display("FAIL reset_re: got %0b expected 0", input_re); end
        tests++; if (input_addr !== '0)     begin fails++; $display("FAIL reset_addr: got %0d expected 0", input_addr); end
        tests++; if (output_we !== 1'b0)    begin fails++; $display("FAIL reset_we: got %0b expected 0", output_we); end
        tests++; if (output_addr !== '0)    begin fails++; $display("FAIL reset_oaddr: got %0d expected 0", output_addr); end
        tests++; if (y !== 8'd0)            begin fails++; $display("FAIL reset_y: got %0d expected 0", y); end
    endtask

    task automatic test_zero_pixels();
        int nw;
        fill_mem_const('0, '0, '0);
        fill_kern_random();
        do_reset();
        capture(N + 10);
        nw = 0;
        for (int k = 0; k < N + 10; k++) begin
            if (cap_we[k] === 1'b1) begin
                tests++; if (cap_oaddr[k] !== AW'(nw)) begin fails++; $display("FAIL zero_addr: got %0d expected %0d", cap_oaddr[k], nw); end
                tests++; if (cap_y[k] !== 8'd0)        begin fails++; $display("FAIL zero_y: got %0d expected 0 at addr %0d", cap_y[k], nw); end
                nw++;
            end
        end
        tests++; if (nw !== N) begin fails++; $display("FAIL zero_count: got %0d writes expected %0d", nw, N); end
        tests++; if (cap_we[3] !== 1'b0 || cap_we[4] !== 1'b1) begin
            fails++; $display("FAIL zero_latency: we[3]=%0b we[4]=%0b expected 0 then 1", cap_we[3], cap_we[4]);
        end
    endtask

    task automatic test_single_tap();
        logic [127:0] blk;
        int nw;
        blk = '0;
        blk[8*5 +: 8]  = 8'd10;
        blk[8*6 +: 8]  = 8'd20;
        blk[8*9 +: 8]  = 8'd30;
        blk[8*10 +: 8] = 8'd40;
        kern[0] = '0; kern[1] = '0; kern[2] = '0;
        kern[0][8*4 +: 8] = 8'h01;
        fill_mem_const(blk, '0, '0);
        do_reset();
        capture(N + 10);
        nw = 0;
        for (int k = 0; k < N + 10; k++) begin
            if (cap_we[k] === 1'b1) begin
                tests++; if (cap_y[k] !== 8'd40) begin fails++; $display("FAIL tap_y: got %0d expected 40 at addr %0d", cap_y[k], cap_oaddr[k]); end
                nw++;
            end
        end
        tests++; if (nw !== N) begin fails++; $display("FAIL tap_count: got %0d writes expected %0d", nw, N); end
    endtask

    task automatic test_saturation();
        int nw;
        fill_mem_const({16{8'hFF}}, {16{8'hFF}}, {16{8'hFF}});
        for (int ch = 0; ch < 3; ch++) kern[ch] = {9{8'h7F}};
        do_reset();
        capture(N + 10);
        nw = 0;
        for (int k = 0; k < N + 10; k++) begin
            if (cap_we[k] === 1'b1) begin
                tests++; if (cap_y[k] !== 8'd255) begin fails++; $display("FAIL sat_y: got %0d expected 255", cap_y[k]); end
                nw++;
            end
        end
        tests++; if (nw !== N) begin fails++; $display("FAIL sat_count: got %0d writes expected %0d", nw, N); end
    endtask

    task automatic test_neg_clamp();
        logic [127:0] blk;
        int nw;
        for (int ch = 0; ch < 3; ch++) kern[ch] = {9{8'h80}};
        do_reset();
        capture(N + 10);
        nw = 0;
        for (int k = 0; k < N + 10; k++) begin
            if (cap_we[k] === 1'b1) begin
                tests++; if (cap_y[k] !== 8'd0) begin fails++; $display("FAIL neg_y: got %0d expected 0", cap_y[k]); end
                nw++;
            end
        end
        tests++; if (nw !== N) begin fails++; $display("FAIL neg_count: got %0d writes expected %0d", nw, N); end

        blk = '0;
        blk[7:0] = 8'd5;
        fill_mem_const(blk, '0, '0);
        kern[0] = '0; kern[1] = '0; kern[2] = '0;
        kern[0][7:0] = 8'hFF;
        do_reset();
        capture(N + 10);
        tests++; if (cap_we[4] !== 1'b1 || cap_y[4] !== 8'd0) begin
            fails++; $display("FAIL mixed_y: we=%0b y=%0d expected we=1 y=0", cap_we[4], cap_y[4]);
        end
    endtask

    task automatic test_random();
        int ey;
        fill_mem_random();
        fill_kern_random();
        do_reset();
        capture(N + 10);
        for (int k = 0; k < N + 10; k++) begin
            tests++; if (cap_re[k] !== (k < N)) begin fails++; $display("FAIL rand_re: cyc %0d got %0b expected %0b", k, cap_re[k], k < N); end
            tests++; if (cap_addr[k] !== AW'((k < N) ? k : 0)) begin fails++; $display("FAIL rand_addr: cyc %0d got %0d expected %0d", k, cap_addr[k], (k < N) ? k : 0); end
            tests++; if (cap_we[k] !== (k >= 4 && k < N + 4)) begin fails++; $display("FAIL rand_we: cyc %0d got %0b", k, cap_we[k]); end
            if (k >= 4 && k < N + 4) begin
                ey = ref_y(k - 4);
                tests++; if (cap_oaddr[k] !== AW'(k - 4)) begin fails++; $display("FAIL rand_oaddr: cyc %0d got %0d expected %0d", k, cap_oaddr[k], k - 4); end
                tests++; if (cap_y[k] !== 8'(ey)) begin fails++; $display("FAIL rand_y: addr %0d got %0d expected %0d", k - 4, cap_y[k], ey); end
            end
        end
    endtask

    task automatic test_mid_reset();
        int ey;
        fill_mem_random();
        fill_kern_random();
        do_reset();
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if (input_re !== 1'b0)  begin fails++; $display("FAIL mid_re: got %0b expected 0", input_re); end
        tests++; if (input_addr !== '0)  begin fails++; $display("FAIL mid_addr: got %0d expected 0", input_addr); end
        tests++; if (output_we !== 1'b0) begin fails++; $display("FAIL mid_we: got %0b expected 0", output_we); end
        tests++; if (output_addr !== '0) begin fails++; $display("FAIL mid_oaddr: got %0d expected 0", output_addr); end
        tests++; if (y !== 8'd0)         begin fails++; $display("FAIL mid_y: got %0d expected 0", y); end
        rst = 1'b0;
        @(negedge clk);
        capture(N + 10);
        for (int k = 0; k < N + 10; k++) begin
            tests++; if (cap_re[k] !== (k < N)) begin fails++; $display("FAIL mid_rd_re: cyc %0d got %0b expected %0b", k, cap_re[k], k < N); end
            tests++; if (cap_addr[k] !== AW'((k < N) ? k : 0)) begin fails++; $display("FAIL mid_rd_addr: cyc %0d got %0d expected %0d", k, cap_addr[k], (k < N) ? k : 0); end
            tests++; if (cap_we[k] !== (k >= 4 && k < N + 4)) begin fails++; $display("FAIL mid_wr_we: cyc %0d got %0b", k, cap_we[k]); end
            if (k >= 4 && k < N + 4) begin
                ey = ref_y(k - 4);
                tests++; if (cap_oaddr[k] !== AW'(k - 4)) begin fails++; $display("FAIL mid_wr_addr: cyc %0d got %0d expected %0d", k, cap_oaddr[k], k - 4); end
                tests++; if (cap_y[k] !== 8'(ey)) begin fails++; $display("FAIL mid_wr_y: addr %0d got %0d expected %0d", k - 4, cap_y[k], ey); end
            end
        end
    endtask

    initial begin
        kern[0] = '0; kern[1] = '0; kern[2] = '0;
        test_reset();
        test_zero_pixels();
        test_single_tap();
        test_saturation();
        test_neg_clamp();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
